// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer
//   Two-entry skid buffer between the execute-stage ALU and the memory stage.
//   It captures the ALU result together with its store data, destination
//   register and memory-op sidebands. Entries leave through a valid/ready
//   handshake in strict FIFO order.
//   IN_READY is decoded from registered state only, so no ready path runs
//   combinationally back into the ALU. A combinational lookup over the
//   buffered entries lets decode/execute bypass the register file.
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   FLUSH               synchronous discard of every buffered entry
//   IN_VALID/IN_READY   upstream handshake
//   IN_RES, IN_STDATA   ALU result, store data          [BITS]
//   IN_RD               destination register            [RBITS]
//   IN_WREN/MEMRD/MEMWR register write, load and store flags
//   OUT_VALID/OUT_READY downstream handshake; OUT_* always come from the head
//   OUT_RES .. OUT_MEMWR head payload
//   FWD_SRC             register index to look up
//   FWD_HIT/FWD_DATA    youngest matching non-load result
//   FWD_STALL           youngest match is a load, so the data is not ready yet
module ex_mem_buffer #(
  parameter int BITS  = 32,
  parameter int RBITS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [BITS-1:0]  IN_RES,
  input  logic [BITS-1:0]  IN_STDATA,
  input  logic [RBITS-1:0] IN_RD,
  input  logic             IN_WREN,
  input  logic             IN_MEMRD,
  input  logic             IN_MEMWR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [BITS-1:0]  OUT_RES,
  output logic [BITS-1:0]  OUT_STDATA,
  output logic [RBITS-1:0] OUT_RD,
  output logic             OUT_WREN,
  output logic             OUT_MEMRD,
  output logic             OUT_MEMWR,
  input  logic [RBITS-1:0] FWD_SRC,
  output logic             FWD_HIT,
  output logic [BITS-1:0]  FWD_DATA,
  output logic             FWD_STALL
);

  typedef struct packed {
    logic [BITS-1:0]  res;
    logic [BITS-1:0]  stdata;
    logic [RBITS-1:0] rd;
    logic             wren;
    logic             memrd;
    logic             memwr;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t h_q, h_d;   // head: always the oldest entry, drives OUT_*
  entry_t s_q, s_d;   // skid: second entry, only meaningful in ST_TWO
  entry_t in_ent;

  logic in_fire, out_fire;

  assign in_ent = '{res: IN_RES, stdata: IN_STDATA, rd: IN_RD,
                    wren: IN_WREN, memrd: IN_MEMRD, memwr: IN_MEMWR};

  // Handshake status comes from state alone.
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign IN_READY  = (state_q != ST_TWO);
  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = OUT_VALID & OUT_READY;

  assign OUT_RES    = h_q.res;
  assign OUT_STDATA = h_q.stdata;
  assign OUT_RD     = h_q.rd;
  assign OUT_WREN   = h_q.wren;
  assign OUT_MEMRD  = h_q.memrd;
  assign OUT_MEMWR  = h_q.memwr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          h_d     = in_ent;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          h_d = in_ent;
        end else if (in_fire) begin
          state_d = ST_TWO;
          s_d     = in_ent;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // IN_READY is low here, so only a pop can happen.
        if (out_fire) begin
          state_d = ST_ONE;
          h_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush empties the buffer. Payload registers are left alone because
    // the state already marks them dead. A pop in the same cycle has still
    // been seen downstream.
    if (FLUSH) state_d = ST_EMPTY;
  end

  // Forwarding lookup. The skid entry is younger than the head, so it wins.
  logic   s_match, h_match;
  entry_t fwd_ent;

  always_comb begin
    s_match   = (state_q == ST_TWO) && s_q.wren && (s_q.rd == FWD_SRC) &&
                (FWD_SRC != '0);
    h_match   = (state_q != ST_EMPTY) && h_q.wren && (h_q.rd == FWD_SRC) &&
                (FWD_SRC != '0);
    fwd_ent   = s_match ? s_q : h_q;
    FWD_HIT   = 1'b0;
    FWD_STALL = 1'b0;
    FWD_DATA  = '0;
    if (s_match || h_match) begin
      if (fwd_ent.memrd) begin
        FWD_STALL = 1'b1;
      end else begin
        FWD_HIT  = 1'b1;
        FWD_DATA = fwd_ent.res;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
module tb_ex_mem_buffer;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] stdata;
    logic [3:0]  rd;
    logic        wren;
    logic        memrd;
    logic        memwr;
  } ent_t;

  logic        gclk = 1'b0;
  logic        RESET, FLUSH, IN_VALID, IN_READY, IN_WREN, IN_MEMRD, IN_MEMWR;
  logic [31:0] IN_RES, IN_STDATA, OUT_RES, OUT_STDATA, FWD_DATA;
  logic [3:0]  IN_RD, OUT_RD, FWD_SRC;
  logic        OUT_VALID, OUT_READY, OUT_WREN, OUT_MEMRD, OUT_MEMWR;
  logic        FWD_HIT, FWD_STALL;

  always #5 gclk = ~gclk;

  ex_mem_buffer #(.BITS(32), .RBITS(4)) dut (
    .CLK(gclk), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_RES(IN_RES), .IN_STDATA(IN_STDATA), .IN_RD(IN_RD),
    .IN_WREN(IN_WREN), .IN_MEMRD(IN_MEMRD), .IN_MEMWR(IN_MEMWR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RES(OUT_RES), .OUT_STDATA(OUT_STDATA), .OUT_RD(OUT_RD),
    .OUT_WREN(OUT_WREN), .OUT_MEMRD(OUT_MEMRD), .OUT_MEMWR(OUT_MEMWR),
    .FWD_SRC(FWD_SRC), .FWD_HIT(FWD_HIT), .FWD_DATA(FWD_DATA),
    .FWD_STALL(FWD_STALL)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is a FIFO of capacity two.
  ent_t        q[$];
  logic [31:0] popped[$];
  logic        stalled_prev = 1'b0;
  ent_t        held;
  // Outputs sampled in the most recent cycle, for directed checks.
  logic        s_in_ready, s_out_valid, s_hit, s_stall;
  logic [31:0] s_out_res, s_data;

  function automatic ent_t mk(input logic [31:0] res, input logic [3:0] rd,
                              input logic wren, input logic memrd);
    ent_t e;
    e.res = res; e.stdata = ~res; e.rd = rd;
    e.wren = wren; e.memrd = memrd; e.memwr = 1'b0;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    int   op;
    e.res = $urandom; e.stdata = $urandom; e.rd = 4'($urandom_range(0, 15));
    e.wren = 1'($urandom_range(0, 1));
    op = $urandom_range(0, 2);
    e.memrd = (op == 1); e.memwr = (op == 2);
    return e;
  endfunction

  // Walk from the youngest entry back to the oldest. The first entry that
  // writes the looked-up register decides the result.
  task automatic model_fwd(input logic [3:0] src, output logic hit,
                           output logic stall, output logic [31:0] data);
    hit = 1'b0; stall = 1'b0; data = '0;
    if (src != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wren && q[i].rd == src) begin
          if (q[i].memrd) stall = 1'b1;
          else begin hit = 1'b1; data = q[i].res; end
          break;
        end
      end
    end
  endtask

  // One clock cycle. Inputs are driven 1 time unit after the rising edge.
  // Outputs are checked at the falling edge. The model advances at the next
  // rising edge.
  task automatic cyc(input logic iv, input logic ordy, input logic fl,
                     input ent_t p, input logic [3:0] fs);
    ent_t        o;
    logic        eh, es, in_f, out_f;
    logic [31:0] ed;
    IN_VALID = iv; OUT_READY = ordy; FLUSH = fl; FWD_SRC = fs;
    IN_RES = p.res; IN_STDATA = p.stdata; IN_RD = p.rd;
    IN_WREN = p.wren; IN_MEMRD = p.memrd; IN_MEMWR = p.memwr;
    @(negedge gclk);
    o = '{res: OUT_RES, stdata: OUT_STDATA, rd: OUT_RD,
          wren: OUT_WREN, memrd: OUT_MEMRD, memwr: OUT_MEMWR};
    s_in_ready = IN_READY; s_out_valid = OUT_VALID; s_out_res = OUT_RES;
    s_hit = FWD_HIT; s_stall = FWD_STALL; s_data = FWD_DATA;
    chk("out_valid", 128'(OUT_VALID), 128'(q.size() != 0));
    chk("in_ready", 128'(IN_READY), 128'(q.size() < 2));
    if (q.size() != 0) chk("head", 128'(o), 128'(q[0]));
    if (stalled_prev) chk("stall_hold", 128'(o), 128'(held));
    model_fwd(fs, eh, es, ed);
    chk("fwd_hit", 128'(FWD_HIT), 128'(eh));
    chk("fwd_stall", 128'(FWD_STALL), 128'(es));
    chk("fwd_data", 128'(FWD_DATA), 128'(ed));
    @(posedge gclk);
    in_f  = iv && (q.size() < 2);
    out_f = (q.size() != 0) && ordy;
    stalled_prev = (q.size() != 0) && !ordy && !fl;
    held = o;
    if (out_f) begin popped.push_back(q[0].res); void'(q.pop_front()); end
    if (fl) q.delete();
    else if (in_f) q.push_back(p);
    #1;
  endtask

  initial begin
    ent_t z;
    int   n0;
    z = '0;
    RESET = 1'b1; FLUSH = 0; IN_VALID = 0; OUT_READY = 0; FWD_SRC = 0;
    IN_RES = 0; IN_STDATA = 0; IN_RD = 0; IN_WREN = 0; IN_MEMRD = 0; IN_MEMWR = 0;
    #3;
    chk("rst_out_valid", 128'(OUT_VALID), 128'(0));
    chk("rst_in_ready", 128'(IN_READY), 128'(1));
    chk("rst_out_res", 128'(OUT_RES), 128'(0));
    #9 RESET = 1'b0;
    @(posedge gclk); #1;

    // Back-pressure: two pushes with OUT_READY low, then drain.
    cyc(1, 0, 0, mk(32'h11, 1, 1, 0), 0);
    cyc(1, 0, 0, mk(32'h22, 2, 1, 0), 0);
    cyc(0, 0, 0, z, 0);
    chk("bp_in_ready", 128'(s_in_ready), 128'(0));
    chk("bp_hold", 128'(s_out_res), 128'(32'h11));
    popped.delete();
    cyc(0, 1, 0, z, 0);
    chk("bp_pop1", 128'(s_out_res), 128'(32'h11));
    cyc(0, 1, 0, z, 0);
    chk("bp_rdy_after_pop", 128'(s_in_ready), 128'(1));
    chk("bp_pop2", 128'(s_out_res), 128'(32'h22));
    chk("bp_order", 128'({popped[0], popped[1]}), 128'({32'h11, 32'h22}));

    // Streaming: one entry in and one out per cycle.
    popped.delete();
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 0, mk(32'(k), 4'(k), 1, 0), 0);
      chk("stream_rdy", 128'(s_in_ready), 128'(1));
    end
    cyc(0, 1, 0, z, 0);
    chk("stream_cnt", 128'(popped.size()), 128'(8));
    for (int k = 0; k < 8 && k < popped.size(); k++)
      chk("stream_val", 128'(popped[k]), 128'(k + 1));

    // Forwarding priority: the skid entry is younger than the head.
    cyc(1, 0, 0, mk(32'hA, 3, 1, 0), 0);
    cyc(1, 0, 0, mk(32'hB, 3, 1, 0), 0);
    cyc(0, 0, 0, z, 3);
    chk("fwd_prio_hit", 128'(s_hit), 128'(1));
    chk("fwd_prio_data", 128'(s_data), 128'(32'hB));
    cyc(0, 0, 1, z, 0);
    cyc(1, 0, 0, mk(32'hA, 3, 1, 0), 0);
    cyc(1, 0, 0, mk(32'hB, 3, 1, 1), 0);
    cyc(0, 0, 0, z, 3);
    chk("fwd_load_stall", 128'(s_stall), 128'(1));
    chk("fwd_load_nohit", 128'(s_hit), 128'(0));
    cyc(0, 0, 0, z, 0);
    chk("fwd_r0", 128'({s_hit, s_stall}), 128'(0));

    // Flush while full, with a push offered and the head being popped.
    popped.delete();
    cyc(1, 1, 1, mk(32'hCC, 5, 1, 0), 0);
    cyc(0, 1, 0, z, 0);
    chk("flush_valid", 128'(s_out_valid), 128'(0));
    chk("flush_rdy", 128'(s_in_ready), 128'(1));
    chk("flush_delivered", 128'(popped.size()), 128'(1));

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 70),
          1'($urandom_range(0, 31) == 0), rnd_ent(), 4'($urandom_range(0, 15)));

    // Asynchronous reset with two entries buffered.
    cyc(0, 0, 1, z, 0);
    cyc(1, 0, 0, mk(32'h55, 5, 1, 0), 0);
    cyc(1, 0, 0, mk(32'h66, 5, 1, 0), 0);
    IN_VALID = 0; FWD_SRC = 4'd5;
    #1 RESET = 1'b1;
    #1;
    chk("arst_out_valid", 128'(OUT_VALID), 128'(0));
    chk("arst_in_ready", 128'(IN_READY), 128'(1));
    chk("arst_out_res", 128'(OUT_RES), 128'(0));
    chk("arst_fwd", 128'(FWD_HIT), 128'(0));
    #1 RESET = 1'b0;
    q.delete(); stalled_prev = 1'b0;
    @(posedge gclk); #1;
    cyc(0, 1, 0, z, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
